// File: rtl/alu_seq.sv
// Handshaked sequential ALU: registered result/flags, valid/ready on both sides, one op in flight.
// Optional iterative signed multiply on opcode 1011 is enabled by defining ALU_SEQ_MUL_EN.
module alu_seq #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             add_sub_overflow,
    output logic             zero,
    output logic             negative,
    output logic             illegal_op
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_VAL = ~MIN_VAL;

    typedef enum logic [1:0] {
        IDLE,
`ifdef ALU_SEQ_MUL_EN
        MUL,
`endif
        HOLD
    } state_t;

    state_t state, next_state;

    logic             accept;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] res;
    logic             res_ovf;
    logic             res_ill;
    logic             is_mul;

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] pp;
    logic [WIDTH:0]     prod_hi;
    logic [SHW-1:0]     cnt;
    logic               cnt_last;
`endif

    assign accept   = in_valid && in_ready;
    assign amt      = operand2[SHW-1:0];
    assign in_ready = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign zero     = (alu_out == '0);
    assign negative = alu_out[WIDTH-1];

    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        res_ill = 1'b0;
        is_mul  = 1'b0;
        case (aluop)
            4'b0000: begin
                res     = '0 - operand1;
                res_ovf = (operand1 == MIN_VAL);
            end
            4'b0001: res = operand1 & operand2;
            4'b0010: res = operand1 ^ operand2;
            4'b0011: res = operand1 | operand2;
            4'b0100: begin
                res     = operand1 - 1'b1;
                res_ovf = (operand1 == MIN_VAL);
            end
            4'b0101: begin
                res     = operand1 + operand2;
                res_ovf = (operand1[WIDTH-1] == operand2[WIDTH-1]) && (res[WIDTH-1] != operand1[WIDTH-1]);
            end
            4'b0110: begin
                res     = operand1 - operand2;
                res_ovf = (operand1[WIDTH-1] != operand2[WIDTH-1]) && (res[WIDTH-1] != operand1[WIDTH-1]);
            end
            4'b0111: begin
                res     = operand1 + 1'b1;
                res_ovf = (operand1 == MAX_VAL);
            end
            4'b1000: res = operand1 << amt;
            4'b1001: res = operand1 >> amt;
            4'b1010: res = $signed(operand1) >>> amt;
`ifdef ALU_SEQ_MUL_EN
            4'b1011: is_mul = 1'b1;
`endif
            default: res_ill = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // Signed multiplier bit WIDTH-1 carries weight -2^(WIDTH-1), so its partial product is subtracted.
    assign cnt_last = (cnt == SHW'(WIDTH - 1));
    assign pp       = {{WIDTH{mul_a[WIDTH-1]}}, mul_a} << cnt;
    assign acc_next = !mul_b[cnt] ? acc : (cnt_last ? acc - pp : acc + pp);
    assign prod_hi  = acc_next[2*WIDTH-1:WIDTH-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    next_state = is_mul ? MUL : HOLD;
`else
                    next_state = HOLD;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL:     if (cnt_last) next_state = HOLD;
`endif
            HOLD:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out          <= '0;
            add_sub_overflow <= 1'b0;
            illegal_op       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mul_a <= '0;
            mul_b <= '0;
            acc   <= '0;
            cnt   <= '0;
`endif
        end else begin
            if (accept && !is_mul) begin
                alu_out          <= res;
                add_sub_overflow <= res_ovf;
                illegal_op       <= res_ill;
            end
`ifdef ALU_SEQ_MUL_EN
            if (accept && is_mul) begin
                mul_a      <= operand1;
                mul_b      <= operand2;
                acc        <= '0;
                cnt        <= '0;
                illegal_op <= 1'b0;
            end
            if (state == MUL) begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
                if (cnt_last) begin
                    alu_out          <= acc_next[WIDTH-1:0];
                    add_sub_overflow <= !((&prod_hi) || !(|prod_hi));
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Vector table plus scoreboard bench for alu_seq; exercises MUL vectors when ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   aluop;
    logic [W-1:0] operand1;
    logic [W-1:0] operand2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_out;
    logic         add_sub_overflow;
    logic         zero;
    logic         negative;
    logic         illegal_op;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ovf;
        logic         ill;
        int           lat;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .operand1(operand1), .operand2(operand2),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .add_sub_overflow(add_sub_overflow),
        .zero(zero), .negative(negative), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] res, input logic ovf, input logic ill, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.ovf = ovf; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_alu_out"}, alu_out, 0);
        check({tag, "_ovf"}, add_sub_overflow, 0);
        check({tag, "_zero"}, zero, 1);
        check({tag, "_negative"}, negative, 0);
        check({tag, "_illegal"}, illegal_op, 0);
    endtask

    // Drive one request, push its expectation, then pop and compare when out_valid rises.
    task automatic issue(input vec_t v);
        int   lat;
        vec_t e;
        @(negedge clk);
        aluop = v.op; operand1 = v.a; operand2 = v.b; in_valid = 1'b1;
        check("in_ready_idle", in_ready, 1);
        sb.push_back(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        aluop = 4'($urandom); operand1 = $urandom; operand2 = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        check("latency", lat, e.lat);
        check("out_valid", out_valid, 1);
        check("in_ready_busy", in_ready, 0);
        check("alu_out", alu_out, e.res);
        check("ovf", add_sub_overflow, e.ovf);
        check("illegal", illegal_op, e.ill);
        check("zero", zero, e.res == '0);
        check("negative", negative, e.res[W-1]);
    endtask

    // Backpressure for a number of cycles with junk on the inputs, then release.
    task automatic hold_release(input int cycles, input vec_t e);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            in_valid = 1'b1; aluop = 4'($urandom); operand1 = $urandom; operand2 = $urandom;
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_out", alu_out, e.res);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
        check("release_out", alu_out, e.res);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        aluop = '0; operand1 = '0; operand2 = '0;
        repeat (2) @(posedge clk);
        #1 check_reset_vals("por");
        @(negedge clk) rst = 1'b0;

        vecs.push_back(mk(4'b0101, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 0, 1));
        vecs.push_back(mk(4'b1010, 32'h80000000, 32'h00000024, 32'hF8000000, 0, 0, 1));
        vecs.push_back(mk(4'b0000, 32'h80000000, 32'h00000000, 32'h80000000, 1, 0, 1));
        vecs.push_back(mk(4'b0000, 32'h00000005, 32'h00000000, 32'hFFFFFFFB, 0, 0, 1));
        vecs.push_back(mk(4'b1110, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 0, 1, 1));
        vecs.push_back(mk(4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 1));
        vecs.push_back(mk(4'b0010, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 0, 0, 1));
        vecs.push_back(mk(4'b0011, 32'h12340000, 32'h00005678, 32'h12345678, 0, 0, 1));
        vecs.push_back(mk(4'b0100, 32'h80000000, 32'h00000000, 32'h7FFFFFFF, 1, 0, 1));
        vecs.push_back(mk(4'b0100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 1));
        vecs.push_back(mk(4'b0111, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 1, 0, 1));
        vecs.push_back(mk(4'b0111, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 0, 0, 1));
        vecs.push_back(mk(4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 0, 1));
        vecs.push_back(mk(4'b0101, 32'h80000000, 32'h80000000, 32'h00000000, 1, 0, 1));
        vecs.push_back(mk(4'b1000, 32'h00000001, 32'h0000001F, 32'h80000000, 0, 0, 1));
        vecs.push_back(mk(4'b1001, 32'h80000000, 32'h00000021, 32'h40000000, 0, 0, 1));
        vecs.push_back(mk(4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 1, 1));
`ifdef ALU_SEQ_MUL_EN
        vecs.push_back(mk(4'b1011, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 0, 0, W + 1));
        vecs.push_back(mk(4'b1011, 32'h00010000, 32'h00010000, 32'h00000000, 1, 0, W + 1));
        vecs.push_back(mk(4'b1011, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, W + 1));
        vecs.push_back(mk(4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0, W + 1));
`else
        vecs.push_back(mk(4'b1011, 32'h00000003, 32'h00000007, 32'h00000000, 0, 1, 1));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i]);
            hold_release(i % 3, vecs[i]);
        end

        // SUB to zero under three cycles of backpressure
        v = mk(4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 0, 0, 1);
        issue(v);
        hold_release(3, v);

        // Reset while holding an illegal result
        v = mk(4'b1100, 32'hDEADBEEF, 32'h00000001, 32'h00000000, 0, 1, 1);
        issue(v);
        @(negedge clk) rst = 1'b1;
        #1 check_reset_vals("rst_hold");
        @(negedge clk) rst = 1'b0;

        // Reset while holding a negative result
        v = mk(4'b0000, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 0, 0, 1);
        issue(v);
        @(negedge clk) rst = 1'b1;
        #1 check_reset_vals("rst_hold_neg");
        @(negedge clk) rst = 1'b0;

`ifdef ALU_SEQ_MUL_EN
        // Reset part-way through a multiply, then confirm the block is usable again
        @(negedge clk);
        aluop = 4'b1011; operand1 = 32'h00000007; operand2 = 32'h00000009; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1 check_reset_vals("rst_mul");
        @(negedge clk) rst = 1'b0;
        v = mk(4'b1011, 32'h00000007, 32'h00000009, 32'h0000003F, 0, 0, W + 1);
        issue(v);
        hold_release(1, v);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
